// File: rtl/restoring_divider_if.sv
// ---------------------------------------------------------------------------
// restoring_divider_if
// Purpose : ALU-bus bundle for the sequential restoring divider. Shares the
//           start/fin handshake with the shift-add multiplier.
// Signals : start        - begin a division (sampled in IDLE or DONE)
//           dividend     - N-bit dividend
//           divisor      - N-bit divisor
//           quotient     - N-bit quotient, valid while fin=1
//           remainder    - N-bit remainder, valid while fin=1
//           busy         - operation in progress
//           fin          - result ready, held until next start or reset
//           div_by_zero  - result produced by a zero divisor
// Modports: master drives start/operands, slave is the divider.
// ---------------------------------------------------------------------------
interface restoring_divider_if #(
    parameter int N = 8
);
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         busy;
    logic         fin;
    logic         div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, fin, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, fin, div_by_zero
    );
endinterface

// File: rtl/restoring_divider.sv
// ---------------------------------------------------------------------------
// restoring_divider
// Purpose : Sequential restoring divider. One quotient bit is produced per
//           SHIFT+SUB state pair; operands are captured in LOAD.
//           Unsigned latency: start seen at edge t+1 -> fin from edge t+2N+2.
//           A zero divisor skips the loop: quotient = all ones,
//           remainder = dividend, div_by_zero = 1.
// Ports   : clk    - single clock, all state changes on posedge
//           reset  - synchronous, active-high; forces IDLE, clears registers
//           bus    - restoring_divider_if.slave (start, dividend, divisor,
//                    quotient, remainder, busy, fin, div_by_zero)
// Config  : SIGNED_DIV_EN - when defined, operands are two's complement.
//           LOAD divides magnitudes and records signs; an extra FIX state
//           restores the signs (quotient truncates toward zero, remainder
//           takes the dividend's sign). Latency becomes 2N+3.
// ---------------------------------------------------------------------------
module restoring_divider #(
    parameter int N = 8
) (
    input logic                 clk,
    input logic                 reset,
    restoring_divider_if.slave  bus
);
    localparam int CW = $clog2(N) + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SHIFT = 3'd2,
        S_SUB   = 3'd3,
        S_FIX   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t        r_state;
    logic [N:0]    r_a;       // partial remainder, one guard bit
    logic [N-1:0]  r_q;       // dividend shifting out, quotient shifting in
    logic [N-1:0]  r_m;       // divisor magnitude
    logic [CW-1:0] r_count;   // quotient bits produced so far
    logic          r_busy;
    logic          r_fin;
    logic          r_dbz;

    logic [N:0]    w_diff;
    logic [CW-1:0] w_count_inc;
    logic [N-1:0]  w_dvd_mag;
    logic [N-1:0]  w_dvs_mag;

`ifdef SIGNED_DIV_EN
    logic r_neg_q;   // operand signs differ
    logic r_neg_r;   // dividend negative

    // Magnitude of the most negative value wraps to itself, which is the
    // correct unsigned magnitude (e.g. 8'h80 = 128).
    assign w_dvd_mag = bus.dividend[N-1] ? -bus.dividend : bus.dividend;
    assign w_dvs_mag = bus.divisor[N-1]  ? -bus.divisor  : bus.divisor;
`else
    assign w_dvd_mag = bus.dividend;
    assign w_dvs_mag = bus.divisor;
`endif

    // Trial subtraction; a set top bit means A < M and A must be kept.
    assign w_diff      = r_a - {1'b0, r_m};
    assign w_count_inc = r_count + 1'b1;

    assign bus.quotient    = r_q;
    assign bus.remainder   = r_a[N-1:0];
    assign bus.busy        = r_busy;
    assign bus.fin         = r_fin;
    assign bus.div_by_zero = r_dbz;

    // NOTE: every register here is assigned with <= so all updates use the
    // values from before the edge; blocking = would let later statements see
    // half-updated state and break the {A,Q} shift/subtract sequencing.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_q     <= '0;
            r_m     <= '0;
            r_count <= '0;
            r_busy  <= 1'b0;
            r_fin   <= 1'b0;
            r_dbz   <= 1'b0;
`ifdef SIGNED_DIV_EN
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state <= S_LOAD;
                        r_busy  <= 1'b1;
                    end
                end

                S_LOAD: begin
                    r_count <= '0;
                    r_m     <= w_dvs_mag;
`ifdef SIGNED_DIV_EN
                    r_neg_q <= bus.dividend[N-1] ^ bus.divisor[N-1];
                    r_neg_r <= bus.dividend[N-1];
`endif
                    if (w_dvs_mag == '0) begin
                        // Divide by zero: publish the fixed result directly.
                        r_a     <= {1'b0, bus.dividend};
                        r_q     <= '1;
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_fin   <= 1'b1;
                        r_dbz   <= 1'b1;
                    end else begin
                        r_a     <= '0;
                        r_q     <= w_dvd_mag;
                        r_state <= S_SHIFT;
                    end
                end

                S_SHIFT: begin
                    {r_a, r_q} <= {r_a[N-1:0], r_q, 1'b0};
                    r_state    <= S_SUB;
                end

                S_SUB: begin
                    r_count <= w_count_inc;
                    if (!w_diff[N]) begin
                        r_a    <= w_diff;
                        r_q[0] <= 1'b1;
                    end
                    if (w_count_inc == CW'(N)) begin
`ifdef SIGNED_DIV_EN
                        r_state <= S_FIX;
`else
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_fin   <= 1'b1;
`endif
                    end else begin
                        r_state <= S_SHIFT;
                    end
                end

`ifdef SIGNED_DIV_EN
                S_FIX: begin
                    if (r_neg_q) r_q <= -r_q;
                    if (r_neg_r) r_a <= {1'b0, -r_a[N-1:0]};
                    r_state <= S_DONE;
                    r_busy  <= 1'b0;
                    r_fin   <= 1'b1;
                end
`endif

                S_DONE: begin
                    if (bus.start) begin
                        r_state <= S_LOAD;
                        r_busy  <= 1'b1;
                        r_fin   <= 1'b0;
                        r_dbz   <= 1'b0;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_fin   <= 1'b0;
                    r_dbz   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_restoring_divider.sv
// ---------------------------------------------------------------------------
// tb_restoring_divider
// Self-checking bench for restoring_divider. A behavioural model built on
// plain / and % gives every expected result and latency; one compare process
// checks the outputs on every falling edge. Directed operations also carry
// hand-computed literal results. Build with SIGNED_DIV_EN for the signed
// variant.
// ---------------------------------------------------------------------------
module tb_restoring_divider;
    localparam int N = 8;

    typedef enum int {MD_OFF, MD_RESET, MD_OP} mode_t;

    logic  clk;
    logic  reset;
    mode_t mode;

    int n_tests;
    int n_fail;

    // Current operation: edges since issue and expected results.
    int           op_k;
    int           exp_lat;
    logic [N-1:0] exp_q;
    logic [N-1:0] exp_r;
    logic         exp_z;
    logic         lit_en;
    logic [N-1:0] lit_q;
    logic [N-1:0] lit_r;
    logic         lit_z;

    restoring_divider_if #(.N(N)) bus ();

    restoring_divider #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: quotient/remainder by arithmetic, latency counted in edges
    // from the edge after which start was driven.
    function automatic void model(input logic [N-1:0] a, input logic [N-1:0] b,
                                  output logic [N-1:0] q, output logic [N-1:0] r,
                                  output logic z, output int lat);
        if (b == '0) begin
            q   = '1;
            r   = a;
            z   = 1'b1;
            lat = 2;
        end else begin
`ifdef SIGNED_DIV_EN
            int sa;
            int sb;
            sa  = int'($signed(a));
            sb  = int'($signed(b));
            q   = N'(sa / sb);
            r   = N'(sa % sb);
            lat = 2 * N + 3;
`else
            q   = a / b;
            r   = a % b;
            lat = 2 * N + 2;
`endif
            z   = 1'b0;
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (op_k=%0d, t=%0t)", name, act, exp, op_k, $time);
        end
    endtask

    // Single compare process.
    always @(negedge clk) begin
        if (mode == MD_RESET) begin
            check("rst_quotient",  32'(bus.quotient),    0);
            check("rst_remainder", 32'(bus.remainder),   0);
            check("rst_busy",      32'(bus.busy),        0);
            check("rst_fin",       32'(bus.fin),         0);
            check("rst_dbz",       32'(bus.div_by_zero), 0);
        end else if (mode == MD_OP && op_k >= 1) begin
            if (op_k < exp_lat) begin
                check("fin_low",   32'(bus.fin),  0);
                check("busy_high", 32'(bus.busy), 1);
            end else begin
                check("fin_high",  32'(bus.fin),         1);
                check("busy_low",  32'(bus.busy),        0);
                check("quotient",  32'(bus.quotient),    32'(exp_q));
                check("remainder", 32'(bus.remainder),   32'(exp_r));
                check("dbz",       32'(bus.div_by_zero), 32'(exp_z));
                if (lit_en && op_k == exp_lat) begin
                    check("lit_quotient",  32'(bus.quotient),    32'(lit_q));
                    check("lit_remainder", 32'(bus.remainder),   32'(lit_r));
                    check("lit_dbz",       32'(bus.div_by_zero), 32'(lit_z));
                    check("model_pin_q",   32'(exp_q),           32'(lit_q));
                    check("model_pin_r",   32'(exp_r),           32'(lit_r));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        op_k++;
        #1;
    endtask

    task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic le, input logic [N-1:0] lq,
                         input logic [N-1:0] lr, input logic lz);
        bus.dividend = a;
        bus.divisor  = b;
        bus.start    = 1'b1;
        model(a, b, exp_q, exp_r, exp_z, exp_lat);
        lit_en = le;
        lit_q  = lq;
        lit_r  = lr;
        lit_z  = lz;
        op_k   = 0;
        mode   = MD_OP;
        tick();
        bus.start = 1'b0;
    endtask

    // Issue, run to fin, then hold `gap` extra cycles in DONE.
    task automatic run(input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic le, input logic [N-1:0] lq,
                       input logic [N-1:0] lr, input logic lz, input int gap);
        issue(a, b, le, lq, lr, lz);
        while (op_k < exp_lat + gap) tick();
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        op_k          = 0;
        exp_lat       = 1;
        exp_q         = '0;
        exp_r         = '0;
        exp_z         = 1'b0;
        lit_en        = 1'b0;
        lit_q         = '0;
        lit_r         = '0;
        lit_z         = 1'b0;
        mode          = MD_RESET;
        // Reset must win over a simultaneous start.
        reset         = 1'b1;
        bus.start     = 1'b1;
        bus.dividend  = 8'd5;
        bus.divisor   = 8'd1;
        repeat (3) tick();
        reset     = 1'b0;
        bus.start = 1'b0;
        repeat (2) tick();

`ifdef SIGNED_DIV_EN
        run(8'hF9, 8'd2,  1'b1, 8'hFD, 8'hFF, 1'b0, 1);   // -7 / 2
        run(8'd7,  8'hFE, 1'b1, 8'hFD, 8'h01, 1'b0, 1);   // 7 / -2
        run(8'h80, 8'hFF, 1'b1, 8'h80, 8'h00, 1'b0, 2);   // -128 / -1
        run(8'd42, 8'd0,  1'b1, 8'hFF, 8'd42, 1'b1, 2);   // 42 / 0
`else
        run(8'd100, 8'd7, 1'b1, 8'd14,  8'd2,  1'b0, 2);
        run(8'd255, 8'd1, 1'b1, 8'd255, 8'd0,  1'b0, 1);  // next start in DONE
        run(8'd17,  8'd20, 1'b1, 8'd0,  8'd17, 1'b0, 2);
        run(8'd42,  8'd0, 1'b1, 8'hFF,  8'd42, 1'b1, 2);
`endif

        // Extra start while busy is ignored; reset mid-operation aborts.
        issue(8'd200, 8'd3, 1'b0, '0, '0, 1'b0);
        while (op_k < 5) tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        while (op_k < 9) tick();
        reset = 1'b1;
        tick();
        mode  = MD_RESET;
        reset = 1'b0;
        @(negedge clk);
        #1;
`ifdef SIGNED_DIV_EN
        run(8'd200, 8'd3, 1'b0, '0, '0, 1'b0, 2);
`else
        run(8'd200, 8'd3, 1'b1, 8'd66, 8'd2, 1'b0, 2);
`endif

        // Randomized operations, mixing back-to-back starts and idle gaps.
        for (int i = 0; i < 60; i++) begin
            logic [N-1:0] a;
            logic [N-1:0] b;
            a = N'($urandom);
            case ($urandom_range(0, 7))
                0:       b = '0;
                1, 2:    b = N'($urandom_range(1, 4));
                default: b = N'($urandom);
            endcase
            run(a, b, 1'b0, '0, '0, 1'b0, int'($urandom_range(1, 3)));
        end

        mode = MD_OFF;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
